ram_rdarb_ctl: RTL and testbench
================================

Name: ram_rdarb_ctl

Overview:
Single-clock access controller for one dual-port block RAM instance (read/write port pair, registered read, 1-cycle read latency, re-gated output).
- Clears the RAM after reset.
- Grants one write requester and round-robin arbitrates two read requesters onto the single read port.
- Returns read data with a valid strobe.
- Drives the RAM's clocks from its own clk, with test and mask tied inactive.

Parameters:
ADDRBIT, 9, RAM address width
DEPTH, 512, number of RAM words; clear sweep covers 0..DEPTH-1
WIDTH, 32, data width
INIT_EN, 1, 1 = zero-fill RAM after reset; 0 = skip clear

Ports:
clk  in  1  block clock; also drives RAM wclk and rclk
rst  in  1  synchronous reset, active-high
wr_req  in  1  write request, held until wr_ack
wr_addr  in  ADDRBIT  write address
wr_data  in  WIDTH  write data
wr_ack  out  1  write accepted this cycle
rd0_req  in  1  client 0 read request, held until rd0_ack
rd0_addr  in  ADDRBIT  client 0 read address
rd0_ack  out  1  client 0 request accepted this cycle
rd0_vld  out  1  client 0 read data valid
rd0_data  out  WIDTH  client 0 read data
rd1_req, rd1_addr, rd1_ack, rd1_vld, rd1_data  same as client 0, for client 1
init_done  out  1  clear sweep finished, controller accepting requests
ram_wa  out  ADDRBIT  RAM write address
ram_we  out  1  RAM write enable
ram_di  out  WIDTH  RAM write data
ram_ra  out  ADDRBIT  RAM read address
ram_re  out  1  RAM read enable
ram_do  in  WIDTH  RAM registered read data
ram_test  out  1  constant 0
ram_mask  out  1  constant 0

Behaviour:
- States:
  - INIT: clear sweep.
  - RUN: normal operation.
  - rst=1 forces INIT and clears the sweep counter to 0 on the next edge, for any state.
- Reset values:
  - init_done=0; wr_ack, rd0_ack, rd1_ack, rd0_vld, rd1_vld = 0.
  - ram_we=0, ram_re=0.
  - Round-robin pointer = client 0.
  - rdN_data is don't-care while rdN_vld=0.
- INIT (INIT_EN=1):
  - Each cycle: ram_we=1, ram_wa=counter, ram_di=0; counter increments.
  - After writing DEPTH-1 (DEPTH cycles total, first write the cycle after rst deasserts): go to RUN, init_done=1.
  - No acks during INIT; requests are ignored and remain pending.
- INIT (INIT_EN=0): go to RUN on the first cycle after rst deasserts; no writes.
- RUN, write side:
  - wr_req=1 gives a combinational same-cycle ack: wr_ack=1, ram_we=1, ram_wa=wr_addr, ram_di=wr_data.
  - Write has priority over reads.
- RUN, read-client selection:
  - If exactly one client requests, it is selected.
  - If both request, the client indicated by the pointer is selected.
  - After any read grant, the pointer moves to the other client.
- RUN, read grant:
  - The grant is qualified by collision: if wr_req=1 and the selected address equals wr_addr, no read grant that cycle. The RAM read-during-write value is undefined, so the client stays pending and retries next cycle (pointer unchanged).
  - Granted: rdN_ack=1, ram_re=1, ram_ra=rdN_addr in the same cycle.
- RUN, read return:
  - The cycle after a grant: rdN_vld=1 for exactly one cycle and rdN_data=ram_do.
  - Data reflects every write acked in earlier cycles.
- ram_re=0 whenever no read is granted. Outputs never forward RAM X data, because vld is only raised following ram_re=1.
- Throughput: one write and one read per cycle. Back-to-back grants to the same client are allowed only when the other client is idle.
- Reset mid-operation:
  - In-flight read: its vld is suppressed.
  - Pending acks are dropped.
  - Clear sweep restarts from address 0.
- Address range: addresses ≥ DEPTH are outside scope. The sweep counter is ADDRBIT bits and compares against DEPTH-1, so non-power-of-2 DEPTH is supported.

Test Plan:
- Reset then idle, INIT_EN=1, DEPTH=512 -> ram_we high 512 consecutive cycles with ram_wa 0..511, ram_di=0; init_done rises the cycle after ram_wa=511; client 0 reads addr 0x1FF -> rd0_vld with data 0.
- Write 0xDEADBEEF to 0x010, then client 0 reads 0x010 next cycle -> rd0_ack same cycle as request, rd0_vld one cycle later with 0xDEADBEEF.
- Both clients request continuously (addrs 0x020 and 0x021) -> acks alternate 0,1,0,1 starting with client 0; each vld follows its ack by one cycle; no cycle with both acks.
- Collision: wr_req addr 0x030 with data 0x5, rd1_req addr 0x030 in the same cycle -> wr_ack=1, rd1_ack=0; rd1_ack next cycle; rd1_data=0x5.
- Requests asserted during INIT -> no acks until init_done=1; first ack in the first RUN cycle.
- rst pulsed one cycle while rd0 grant is in flight -> rd0_vld stays 0, init_done=0, sweep restarts at ram_wa=0; INIT_EN=0 variant -> init_done=1 the first cycle after rst deasserts.

Source files
------------

// File: rtl/ram_rdarb_ctl.sv
`default_nettype none
// ============================================================================
// Module   : ram_rdarb_ctl
// Purpose  : Access controller for one dual-port block RAM with a registered,
//            1-cycle-latency read port. After reset it zero-fills the RAM
//            (when INIT_EN=1). It then grants one write requester and
//            round-robin arbitrates two read clients onto the read port.
//            Read data is returned with a one-cycle valid strobe.
// Ports    : clk, rst                   - clock, synchronous active-high reset
//            wr_req/wr_addr/wr_data     - write request (held until wr_ack)
//            wr_ack                     - write accepted this cycle
//            rdN_req/rdN_addr (N=0,1)   - read requests (held until rdN_ack)
//            rdN_ack/rdN_vld/rdN_data   - grant, return strobe, return data
//            init_done                  - clear sweep finished, running
//            ram_wa/ram_we/ram_di       - RAM write port
//            ram_ra/ram_re/ram_do       - RAM read port (ram_do registered)
//            ram_test/ram_mask          - RAM test/mask, tied inactive
// Revision : 1.0 - initial release
// ============================================================================
module ram_rdarb_ctl #(
    parameter int ADDRBIT = 9,
    parameter int DEPTH   = 512,
    parameter int WIDTH   = 32,
    parameter int INIT_EN = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_req,
    input  logic [ADDRBIT-1:0] wr_addr,
    input  logic [WIDTH-1:0]   wr_data,
    output logic               wr_ack,
    input  logic               rd0_req,
    input  logic [ADDRBIT-1:0] rd0_addr,
    output logic               rd0_ack,
    output logic               rd0_vld,
    output logic [WIDTH-1:0]   rd0_data,
    input  logic               rd1_req,
    input  logic [ADDRBIT-1:0] rd1_addr,
    output logic               rd1_ack,
    output logic               rd1_vld,
    output logic [WIDTH-1:0]   rd1_data,
    output logic               init_done,
    output logic [ADDRBIT-1:0] ram_wa,
    output logic               ram_we,
    output logic [WIDTH-1:0]   ram_di,
    output logic [ADDRBIT-1:0] ram_ra,
    output logic               ram_re,
    input  logic [WIDTH-1:0]   ram_do,
    output logic               ram_test,
    output logic               ram_mask
);

    localparam logic [0:0]         c_ST_INIT = 1'b0;
    localparam logic [0:0]         c_ST_RUN  = 1'b1;
    localparam logic [ADDRBIT-1:0] c_LAST    = ADDRBIT'(DEPTH - 1);

    logic [0:0]         r_state;
    logic [0:0]         w_nstate;
    logic [ADDRBIT-1:0] r_cnt;
    logic               r_ptr;    // 0 = client 0 wins a tie, 1 = client 1
    logic               r_vld0;
    logic               r_vld1;

    logic               w_run;
    logic               w_sel1;   // client 1 is the arbitration winner
    logic               w_rgnt;   // a read is granted this cycle
    logic [ADDRBIT-1:0] w_sel_addr;

    // ------------------------------------------------------------------
    // State register and sequential bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_INIT;
            r_cnt   <= '0;
            r_ptr   <= 1'b0;
            r_vld0  <= 1'b0;
            r_vld1  <= 1'b0;
        end else begin
            r_state <= w_nstate;
            if (r_state == c_ST_INIT) begin
                r_cnt <= r_cnt + 1'b1;
            end
            // Pointer hands priority to the client that was not just served.
            if (w_rgnt) begin
                r_ptr <= ~w_sel1;
            end
            r_vld0 <= w_rgnt & ~w_sel1;
            r_vld1 <= w_rgnt &  w_sel1;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_nstate = r_state;
        case (r_state)
            c_ST_INIT: begin
                if (INIT_EN == 0) begin
                    w_nstate = c_ST_RUN;
                end else if (r_cnt == c_LAST) begin
                    w_nstate = c_ST_RUN;
                end
            end
            default: w_nstate = c_ST_RUN;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic. Every grant is masked by rst so that a reset cycle
    // drops pending acks and hides a return that is already in flight.
    // ------------------------------------------------------------------
    always_comb begin
        w_run      = (r_state == c_ST_RUN) && !rst;
        w_sel1     = rd1_req && (!rd0_req || r_ptr);
        w_sel_addr = w_sel1 ? rd1_addr : rd0_addr;
        // The RAM's read-during-write result is undefined, so a read that
        // hits the address being written this cycle waits one cycle. The
        // pointer is left alone because no grant is made.
        w_rgnt     = w_run && (rd0_req || rd1_req)
                     && !(wr_req && (w_sel_addr == wr_addr));

        wr_ack    = w_run && wr_req;
        rd0_ack   = w_rgnt && !w_sel1;
        rd1_ack   = w_rgnt &&  w_sel1;
        rd0_vld   = r_vld0 && !rst;
        rd1_vld   = r_vld1 && !rst;
        rd0_data  = ram_do;
        rd1_data  = ram_do;
        init_done = w_run;

        ram_we = 1'b0;
        ram_wa = wr_addr;
        ram_di = wr_data;
        if (r_state == c_ST_INIT) begin
            ram_we = (INIT_EN != 0) && !rst;
            ram_wa = r_cnt;
            ram_di = '0;
        end else begin
            ram_we = wr_ack;
        end

        ram_re   = w_rgnt;
        ram_ra   = w_sel_addr;
        ram_test = 1'b0;
        ram_mask = 1'b0;
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_rdarb_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_rdarb_ctl
// Purpose  : Directed self-checking bench for ram_rdarb_ctl with a behavioural
//            registered-read RAM. A second instance with INIT_EN=0 shares
//            clk/rst and is used to check that it skips the clear sweep.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_rdarb_ctl;

    localparam int ADDRBIT = 9;
    localparam int DEPTH   = 512;
    localparam int WIDTH   = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic               wr_req;
    logic [ADDRBIT-1:0] wr_addr;
    logic [WIDTH-1:0]   wr_data;
    logic               wr_ack;
    logic               rd0_req, rd1_req;
    logic [ADDRBIT-1:0] rd0_addr, rd1_addr;
    logic               rd0_ack, rd1_ack, rd0_vld, rd1_vld;
    logic [WIDTH-1:0]   rd0_data, rd1_data;
    logic               init_done;
    logic [ADDRBIT-1:0] ram_wa, ram_ra;
    logic               ram_we, ram_re, ram_test, ram_mask;
    logic [WIDTH-1:0]   ram_di, ram_do;

    // Second instance (INIT_EN=0), requests tied idle
    logic               n_wr_ack, n_rd0_ack, n_rd1_ack, n_rd0_vld, n_rd1_vld;
    logic [WIDTH-1:0]   n_rd0_data, n_rd1_data, n_ram_di;
    logic               n_init_done, n_ram_we, n_ram_re, n_ram_test, n_ram_mask;
    logic [ADDRBIT-1:0] n_ram_wa, n_ram_ra;

    logic [WIDTH-1:0] mem [DEPTH];

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    ram_rdarb_ctl #(.ADDRBIT(ADDRBIT), .DEPTH(DEPTH), .WIDTH(WIDTH), .INIT_EN(1)) u_dut (
        .clk(clk), .rst(rst),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .rd0_req(rd0_req), .rd0_addr(rd0_addr), .rd0_ack(rd0_ack), .rd0_vld(rd0_vld), .rd0_data(rd0_data),
        .rd1_req(rd1_req), .rd1_addr(rd1_addr), .rd1_ack(rd1_ack), .rd1_vld(rd1_vld), .rd1_data(rd1_data),
        .init_done(init_done),
        .ram_wa(ram_wa), .ram_we(ram_we), .ram_di(ram_di),
        .ram_ra(ram_ra), .ram_re(ram_re), .ram_do(ram_do),
        .ram_test(ram_test), .ram_mask(ram_mask)
    );

    ram_rdarb_ctl #(.ADDRBIT(ADDRBIT), .DEPTH(DEPTH), .WIDTH(WIDTH), .INIT_EN(0)) u_dut_ni (
        .clk(clk), .rst(rst),
        .wr_req(1'b0), .wr_addr('0), .wr_data('0), .wr_ack(n_wr_ack),
        .rd0_req(1'b0), .rd0_addr('0), .rd0_ack(n_rd0_ack), .rd0_vld(n_rd0_vld), .rd0_data(n_rd0_data),
        .rd1_req(1'b0), .rd1_addr('0), .rd1_ack(n_rd1_ack), .rd1_vld(n_rd1_vld), .rd1_data(n_rd1_data),
        .init_done(n_init_done),
        .ram_wa(n_ram_wa), .ram_we(n_ram_we), .ram_di(n_ram_di),
        .ram_ra(n_ram_ra), .ram_re(n_ram_re), .ram_do('0),
        .ram_test(n_ram_test), .ram_mask(n_ram_mask)
    );

    // Behavioural RAM: synchronous write, registered read
    always @(posedge clk) begin
        if (ram_we) mem[ram_wa] <= ram_di;
        if (ram_re) ram_do <= mem[ram_ra];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        rd0_req = 1'b0; rd0_addr = '0; rd1_req = 1'b0; rd1_addr = '0;

        // ---------------- reset state ----------------
        tick(); tick();
        smp();
        chk("rst_outs", {init_done, ram_we, ram_re, wr_ack, rd0_ack, rd1_ack, rd0_vld, rd1_vld}, 8'h00);
        chk("rst_ties", {ram_test, ram_mask}, 2'b00);
        chk("rst_ni_init_done", n_init_done, 1'b0);

        // ---------------- clear sweep ----------------
        tick(); rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            smp();
            chk($sformatf("sweep_%0d", i), {ram_we, ram_wa, ram_di, init_done, n_ram_we},
                {1'b1, ADDRBIT'(i), {WIDTH{1'b0}}, 1'b0, 1'b0});
            if (i == 1) chk("ni_init_done", n_init_done, 1'b1);
            tick();
        end
        smp();
        chk("sweep_done", {init_done, ram_we}, 2'b10);

        // client 0 reads last address -> cleared data
        rd0_req = 1'b1; rd0_addr = 9'h1FF;
        smp();
        chk("rd_1ff_ack", {rd0_ack, rd1_ack, ram_re, ram_ra}, {3'b101, 9'h1FF});
        tick(); rd0_req = 1'b0;
        smp();
        chk("rd_1ff_ret", {rd0_vld, rd1_vld, rd0_ack, rd0_data}, {3'b100, 32'h0});

        // ---------------- write then read ----------------
        wr_req = 1'b1; wr_addr = 9'h010; wr_data = 32'hDEADBEEF;
        smp();
        chk("wr10_ack", {wr_ack, ram_we, ram_wa, ram_di}, {2'b11, 9'h010, 32'hDEADBEEF});
        tick(); wr_addr = 9'h020; wr_data = 32'h0000A0A0;
        rd0_req = 1'b1; rd0_addr = 9'h010;
        smp();
        chk("rd10_ack", {rd0_ack, wr_ack}, 2'b11);
        tick(); rd0_req = 1'b0; wr_addr = 9'h021; wr_data = 32'h0000B1B1;
        smp();
        chk("rd10_ret", {rd0_vld, rd0_data}, {1'b1, 32'hDEADBEEF});
        tick(); wr_req = 1'b0;
        // client 1 read hands the pointer back to client 0
        rd1_req = 1'b1; rd1_addr = 9'h021;
        smp();
        chk("rd21_ack", {rd0_ack, rd1_ack}, 2'b01);
        tick();

        // ---------------- both clients contend ----------------
        rd0_req = 1'b1; rd0_addr = 9'h020; rd1_addr = 9'h021;
        smp();
        chk("rd21_ret", {rd1_vld, rd1_data}, {1'b1, 32'h0000B1B1});
        for (int k = 0; k < 4; k++) begin
            if (k > 0) smp();
            chk($sformatf("rr_ack_%0d", k), {rd0_ack, rd1_ack}, (k % 2 == 0) ? 2'b10 : 2'b01);
            if (k > 0)
                chk($sformatf("rr_ret_%0d", k), {rd0_vld, rd1_vld, ram_do},
                    (k % 2 == 1) ? {2'b10, 32'h0000A0A0} : {2'b01, 32'h0000B1B1});
            tick();
        end
        rd0_req = 1'b0; rd1_req = 1'b0;
        smp();
        chk("rr_last_ret", {rd0_vld, rd1_vld, rd1_data}, {2'b01, 32'h0000B1B1});

        // ---------------- write/read collision ----------------
        tick();
        wr_req = 1'b1; wr_addr = 9'h030; wr_data = 32'h5;
        rd1_req = 1'b1; rd1_addr = 9'h030;
        smp();
        chk("coll_hold", {wr_ack, rd1_ack, ram_re}, 3'b100);
        tick(); wr_req = 1'b0;
        smp();
        chk("coll_retry", {rd1_ack, ram_ra}, {1'b1, 9'h030});
        tick(); rd1_req = 1'b0;
        smp();
        chk("coll_ret", {rd1_vld, rd1_data}, {1'b1, 32'h5});

        // ---------------- reset with a read in flight ----------------
        tick();
        rd0_req = 1'b1; rd0_addr = 9'h010;
        smp();
        chk("inflt_ack", rd0_ack, 1'b1);
        tick(); rd0_req = 1'b0; rst = 1'b1;
        rd1_req = 1'b1; rd1_addr = 9'h021;
        smp();
        chk("inflt_vld_masked", {rd0_vld, rd1_ack, init_done, n_init_done}, 4'b0000);
        tick(); rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            smp();
            chk($sformatf("sweep2_%0d", i), {ram_we, ram_wa, rd0_vld, rd1_ack, init_done},
                {1'b1, ADDRBIT'(i), 3'b000});
            tick();
        end
        smp();
        chk("pend_first_ack", {init_done, rd1_ack}, 2'b11);
        tick(); rd1_req = 1'b0;
        smp();
        chk("pend_ret_cleared", {rd1_vld, rd1_data}, {1'b1, 32'h0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
